// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit.
//   - HB_* access-size encodings carried on core_hb_i
//   - lsu_state_e FSM state enum
//   - region decode constants (REGION_SHIFT, ROM/RAM/UART indices)
//   - is_misaligned() helper used by the request decoder
package lsu_pkg;

  localparam logic [1:0] HB_BYTE = 2'b00;
  localparam logic [1:0] HB_HALF = 2'b01;
  localparam logic [1:0] HB_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  localparam int REGION_SHIFT = 8;
  localparam int ROM_IDX      = 0;
  localparam int RAM_IDX      = 1;
  localparam int UART_IDX     = 2;

  // Halfwords must sit on even addresses, words on 4-byte boundaries.
  function automatic logic is_misaligned(input logic [1:0] hb, input logic [1:0] off);
    return ((hb == HB_HALF) && off[0]) || ((hb == HB_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: combinational byte-lane steering for the load/store unit.
// Ports:
//   off, hb, uns  - byte offset, access size and zero-extend flag
//   st_data       - right-justified store data from the core
//   bus_wdata     - store data replicated across all lanes of that size
//   bus_be        - byte enables for the addressed lanes
//   ld_raw        - raw 32-bit word returned by the selected slave
//   ld_data       - addressed lanes shifted down and sign/zero extended
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  hb,
  input  logic        uns,
  input  logic [31:0] st_data,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  function automatic logic [31:0] ext_byte(input logic signed [7:0] v, input logic u);
    logic signed [31:0] s;
    s = v;
    return u ? {24'h0, v} : s;
  endfunction

  function automatic logic [31:0] ext_half(input logic signed [15:0] v, input logic u);
    logic signed [31:0] s;
    s = v;
    return u ? {16'h0, v} : s;
  endfunction

  always_comb begin
    bus_wdata = st_data;
    bus_be    = 4'b0000;
    ld_data   = ld_raw;
    case (hb)
      HB_BYTE: begin
        bus_wdata = {4{st_data[7:0]}};
        bus_be    = 4'b0001 << off;
        ld_data   = ext_byte(ld_raw[{off, 3'b000} +: 8], uns);
      end
      HB_HALF: begin
        bus_wdata = {2{st_data[15:0]}};
        bus_be    = 4'b0011 << off;
        ld_data   = ext_half(ld_raw[{off[1], 4'b0000} +: 16], uns);
      end
      HB_WORD: begin
        bus_wdata = st_data;
        bus_be    = 4'b1111;
        ld_data   = ld_raw;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_bus.sv
// lsu_bus: registered load/store unit between the core and the peripheral bus.
// Decodes the address into one of N_SLAVES 256-byte regions, runs a cs/ack
// handshake, steers byte lanes and reports misaligned, unmapped and (optionally)
// timed-out accesses as error responses.
// Optional feature: define LSU_TIMEOUT_EN to abort an access after
// TIMEOUT_CYCLES ACCESS cycles without an ack.
// Ports:
//   clk_i, rst_i                    - clock, synchronous active-high reset
//   core_req_i/core_ready_o         - request handshake (ready while idle)
//   core_addr_i/wdata_i/we_i/hb_i/uns_i - request fields
//   core_valid_o/err_o/rdata_o      - one-cycle response
//   bus_addr_o/wdata_o/we_o/be_o/cs_o - registered bus request
//   slv_rdata_i/slv_ack_i           - per-slave read data and acknowledge
module lsu_bus
  import lsu_pkg::*;
#(
  parameter int N_SLAVES       = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     core_req_i,
  output logic                     core_ready_o,
  input  logic [31:0]              core_addr_i,
  input  logic [31:0]              core_wdata_i,
  input  logic                     core_we_i,
  input  logic [1:0]               core_hb_i,
  input  logic                     core_uns_i,
  output logic                     core_valid_o,
  output logic                     core_err_o,
  output logic [31:0]              core_rdata_o,
  output logic [31:0]              bus_addr_o,
  output logic [31:0]              bus_wdata_o,
  output logic                     bus_we_o,
  output logic [3:0]               bus_be_o,
  output logic [N_SLAVES-1:0]      bus_cs_o,
  input  logic [32*N_SLAVES-1:0]   slv_rdata_i,
  input  logic [N_SLAVES-1:0]      slv_ack_i
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_tmo_range
    $error("lsu_bus: TIMEOUT_CYCLES must be in 1..255");
  end

  localparam logic [8:0] N_SLV9 = 9'(N_SLAVES);

  lsu_state_e  state;
  logic [1:0]  off_q;
  logic [1:0]  hb_q;
  logic        uns_q;
  logic [7:0]  region_q;

  logic                req_err;
  logic [N_SLAVES-1:0] cs_dec;
  logic [31:0]         sel_rdata;
  logic                sel_ack;
  logic                tmo_hit;

  logic [1:0]  lane_off;
  logic [1:0]  lane_hb;
  logic        lane_uns;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_be;
  logic [31:0] lane_ld;

  assign core_ready_o = (state == ST_IDLE);

  assign req_err = (core_hb_i == 2'b11)
                || is_misaligned(core_hb_i, core_addr_i[1:0])
                || (core_addr_i[31:16] != 16'h0)
                || ({1'b0, core_addr_i[15:8]} >= N_SLV9);

  always_comb begin
    cs_dec = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (core_addr_i[15:REGION_SHIFT] == 8'(i)) cs_dec[i] = 1'b1;
    end
  end

  // Only the selected slave's data and ack are ever looked at.
  always_comb begin
    sel_rdata = '0;
    sel_ack   = 1'b0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (region_q == 8'(i)) begin
        sel_rdata = slv_rdata_i[32*i +: 32];
        sel_ack   = slv_ack_i[i];
      end
    end
  end

  // The single lane instance steers the incoming request while idle (store
  // path) and the registered request afterwards (load path).
  always_comb begin
    lane_off = core_ready_o ? core_addr_i[1:0] : off_q;
    lane_hb  = core_ready_o ? core_hb_i        : hb_q;
    lane_uns = core_ready_o ? core_uns_i       : uns_q;
  end

  lsu_lane u_lane (
    .off       (lane_off),
    .hb        (lane_hb),
    .uns       (lane_uns),
    .st_data   (core_wdata_i),
    .bus_wdata (lane_wdata),
    .bus_be    (lane_be),
    .ld_raw    (sel_rdata),
    .ld_data   (lane_ld)
  );

`ifdef LSU_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt <= 8'h0;
    end else if (state == ST_ACCESS) begin
      tmo_cnt <= tmo_cnt + 8'h1;
    end else begin
      tmo_cnt <= 8'h0;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      off_q        <= 2'b00;
      hb_q         <= 2'b00;
      uns_q        <= 1'b0;
      region_q     <= 8'h0;
      core_valid_o <= 1'b0;
      core_err_o   <= 1'b0;
      core_rdata_o <= 32'h0;
      bus_addr_o   <= 32'h0;
      bus_wdata_o  <= 32'h0;
      bus_we_o     <= 1'b0;
      bus_be_o     <= 4'h0;
      bus_cs_o     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          core_valid_o <= 1'b0;
          core_err_o   <= 1'b0;
          if (core_req_i) begin
            off_q    <= core_addr_i[1:0];
            hb_q     <= core_hb_i;
            uns_q    <= core_uns_i;
            region_q <= core_addr_i[15:REGION_SHIFT];
            if (req_err) begin
              // Rejected requests never touch the bus.
              state        <= ST_RESP;
              core_valid_o <= 1'b1;
              core_err_o   <= 1'b1;
              core_rdata_o <= 32'h0;
            end else begin
              state       <= ST_ACCESS;
              bus_addr_o  <= {24'h0, core_addr_i[7:0]};
              bus_wdata_o <= lane_wdata;
              bus_we_o    <= core_we_i;
              bus_be_o    <= lane_be;
              bus_cs_o    <= cs_dec;
            end
          end
        end
        ST_ACCESS: begin
          // Ack wins over a timeout reached in the same cycle.
          if (sel_ack || tmo_hit) begin
            state        <= ST_RESP;
            core_valid_o <= 1'b1;
            core_err_o   <= !sel_ack;
            bus_addr_o   <= 32'h0;
            bus_wdata_o  <= 32'h0;
            bus_we_o     <= 1'b0;
            bus_be_o     <= 4'h0;
            bus_cs_o     <= '0;
            if (!sel_ack)      core_rdata_o <= 32'h0;
            else if (!bus_we_o) core_rdata_o <= lane_ld;
          end
        end
        ST_RESP: begin
          state        <= ST_IDLE;
          core_valid_o <= 1'b0;
          core_err_o   <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus.sv
module tb_lsu_bus;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        core_req_i;
  logic        core_ready_o;
  logic [31:0] core_addr_i;
  logic [31:0] core_wdata_i;
  logic        core_we_i;
  logic [1:0]  core_hb_i;
  logic        core_uns_i;
  logic        core_valid_o;
  logic        core_err_o;
  logic [31:0] core_rdata_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_we_o;
  logic [3:0]  bus_be_o;
  logic [2:0]  bus_cs_o;
  logic [95:0] slv_rdata_i;
  logic [2:0]  slv_ack_i;

  int n_cmp = 0;
  int n_bad = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  lsu_bus #(.N_SLAVES(3), .TIMEOUT_CYCLES(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .core_req_i   (core_req_i),
    .core_ready_o (core_ready_o),
    .core_addr_i  (core_addr_i),
    .core_wdata_i (core_wdata_i),
    .core_we_i    (core_we_i),
    .core_hb_i    (core_hb_i),
    .core_uns_i   (core_uns_i),
    .core_valid_o (core_valid_o),
    .core_err_o   (core_err_o),
    .core_rdata_o (core_rdata_o),
    .bus_addr_o   (bus_addr_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_we_o     (bus_we_o),
    .bus_be_o     (bus_be_o),
    .bus_cs_o     (bus_cs_o),
    .slv_rdata_i  (slv_rdata_i),
    .slv_ack_i    (slv_ack_i)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Response monitor: every valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst_i && core_valid_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL resp_unexpected: got err=%0d rdata=0x%08h want no response",
                 core_err_o, core_rdata_o);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("resp_err", 32'(core_err_o), 32'(e[32]));
        chk("resp_rdata", core_rdata_o, e[31:0]);
        chk("resp_cs_low", 32'(bus_cs_o), 32'h0);
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!core_ready_o && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", 32'(core_ready_o), 32'h1);
  endtask

  task automatic issue(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                       input logic [1:0] hb, input logic uns);
    wait_ready();
    core_req_i   = 1'b1;
    core_addr_i  = addr;
    core_wdata_i = wdata;
    core_we_i    = we;
    core_hb_i    = hb;
    core_uns_i   = uns;
    @(posedge clk); #1;
    core_req_i   = 1'b0;
  endtask

  // One complete transaction with a hand-computed expected bus request and response.
  task automatic access(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic we, input logic [1:0] hb, input logic uns,
                        input logic [2:0] exp_cs, input logic [3:0] exp_be,
                        input logic [31:0] exp_bwdata, input int waits,
                        input logic exp_err, input logic [31:0] exp_rdata);
    exp_q.push_back({exp_err, exp_rdata});
    issue(addr, wdata, we, hb, uns);
    chk({name, "_cs"}, 32'(bus_cs_o), 32'(exp_cs));
    if (!exp_err) begin
      chk({name, "_be"}, 32'(bus_be_o), 32'(exp_be));
      chk({name, "_addr"}, bus_addr_o, {24'h0, addr[7:0]});
      chk({name, "_we"}, 32'(bus_we_o), 32'(we));
      if (we) chk({name, "_wdata"}, bus_wdata_o, exp_bwdata);
      chk({name, "_busy"}, 32'(core_ready_o), 32'h0);
      for (int w = 0; w < waits; w++) begin
        slv_ack_i = ~exp_cs;
        @(posedge clk); #1;
        chk({name, "_cs_hold"}, 32'(bus_cs_o), 32'(exp_cs));
      end
      slv_ack_i = exp_cs;
      @(posedge clk); #1;
      slv_ack_i = 3'b000;
      chk({name, "_cs_drop"}, 32'(bus_cs_o), 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst_i        = 1'b1;
    core_req_i   = 1'b0;
    core_addr_i  = 32'h0;
    core_wdata_i = 32'h0;
    core_we_i    = 1'b0;
    core_hb_i    = 2'b00;
    core_uns_i   = 1'b0;
    slv_ack_i    = 3'b000;
    slv_rdata_i  = {32'h55667788, 32'h11223344, 32'h80AABBCC};
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;

    chk("rst_ready", 32'(core_ready_o), 32'h1);
    chk("rst_valid", 32'(core_valid_o), 32'h0);
    chk("rst_err", 32'(core_err_o), 32'h0);
    chk("rst_rdata", core_rdata_o, 32'h0);
    chk("rst_cs", 32'(bus_cs_o), 32'h0);
    chk("rst_be", 32'(bus_be_o), 32'h0);
    chk("rst_baddr", bus_addr_o, 32'h0);

    //      name    addr         wdata         we    hb     uns   cs      be       bus wdata     w  err   rdata
    access("st_w",  32'h104, 32'hDEADBEEF, 1'b1, 2'b10, 1'b0, 3'b010, 4'b1111, 32'hDEADBEEF, 2, 1'b0, 32'h0);
    access("ld_bs", 32'h003, 32'h0,        1'b0, 2'b00, 1'b0, 3'b001, 4'b1000, 32'h0,        0, 1'b0, 32'hFFFFFF80);
    access("ld_bu", 32'h003, 32'h0,        1'b0, 2'b00, 1'b1, 3'b001, 4'b1000, 32'h0,        1, 1'b0, 32'h00000080);
    access("st_h",  32'h202, 32'h00001234, 1'b1, 2'b01, 1'b0, 3'b100, 4'b1100, 32'h12341234, 1, 1'b0, 32'h00000080);
    access("e_mis", 32'h102, 32'h0,        1'b0, 2'b10, 1'b0, 3'b000, 4'b0000, 32'h0,        0, 1'b1, 32'h0);
    access("e_map", 32'h300, 32'h0,        1'b0, 2'b00, 1'b0, 3'b000, 4'b0000, 32'h0,        0, 1'b1, 32'h0);
    access("ld_hs", 32'h106, 32'h0,        1'b0, 2'b01, 1'b0, 3'b010, 4'b1100, 32'h0,        0, 1'b0, 32'h00001122);
    access("ld_hn", 32'h000, 32'h0,        1'b0, 2'b01, 1'b0, 3'b001, 4'b0011, 32'h0,        3, 1'b0, 32'hFFFFBBCC);
    access("e_hb3", 32'h100, 32'h0,        1'b0, 2'b11, 1'b0, 3'b000, 4'b0000, 32'h0,        0, 1'b1, 32'h0);
    access("e_hi",  32'h10000, 32'h0,      1'b0, 2'b00, 1'b0, 3'b000, 4'b0000, 32'h0,        0, 1'b1, 32'h0);
    access("e_hmis",32'h001, 32'h0,        1'b0, 2'b01, 1'b0, 3'b000, 4'b0000, 32'h0,        0, 1'b1, 32'h0);
    access("st_b",  32'h101, 32'h000000A5, 1'b1, 2'b00, 1'b0, 3'b010, 4'b0010, 32'hA5A5A5A5, 0, 1'b0, 32'h0);

    // Reset during the first ACCESS cycle: no response, bus released at once.
    issue(32'h100, 32'h0, 1'b0, 2'b10, 1'b0);
    chk("abort_cs_on", 32'(bus_cs_o), 32'h2);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    chk("abort_cs", 32'(bus_cs_o), 32'h0);
    chk("abort_ready", 32'(core_ready_o), 32'h1);
    repeat (3) @(posedge clk);
    #1;

    access("ld_w",  32'h200, 32'h0,        1'b0, 2'b10, 1'b0, 3'b100, 4'b1111, 32'h0,        0, 1'b0, 32'h55667788);

    // Silent UART.
`ifdef LSU_TIMEOUT_EN
    exp_q.push_back({1'b1, 32'h0});
    issue(32'h204, 32'h0, 1'b0, 2'b10, 1'b0);
    cyc = 0;
    while (bus_cs_o[2] && cyc < 200) begin
      cyc++;
      @(posedge clk); #1;
    end
    chk("tmo_cycles", 32'(cyc), 32'd16);
`else
    exp_q.push_back({1'b0, 32'h55667788});
    issue(32'h204, 32'h0, 1'b0, 2'b10, 1'b0);
    repeat (100) @(posedge clk);
    #1;
    chk("no_tmo_cs", 32'(bus_cs_o), 32'h4);
    slv_ack_i = 3'b100;
    @(posedge clk); #1;
    slv_ack_i = 3'b000;
    cyc = 0;
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("final_ready", 32'(core_ready_o), 32'h1);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_bus.md
# lsu_bus

Parametrised, registered load/store unit between the core and the memory-mapped peripheral bus. It decodes the core address into one of N_SLAVES 256-byte regions and drives a one-hot chip select. It runs a request/acknowledge handshake with per-slave wait states, performs byte-lane steering with sign/zero extension, and reports misaligned, unmapped and timed-out accesses as errors instead of defaulting to ROM.

## Interface
- N_SLAVES, 3, number of slave regions; region i covers 0x0000_i00–0x0000_iFF (0=ROM, 1=RAM, 2=UART)
- TIMEOUT_CYCLES, 16, maximum ACCESS-state cycles before a timeout error (only used with LSU_TIMEOUT_EN)
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- core_req_i  in  1  access request, sampled when core_ready_o=1
- core_ready_o  out  1  LSU idle, can accept a request
- core_addr_i  in  32  byte address
- core_wdata_i  in  32  store data, right-justified
- core_we_i  in  1  1=store, 0=load
- core_hb_i  in  2  size: 00 byte, 01 half, 10 word, 11 illegal
- core_uns_i  in  1  load zero-extends when 1, sign-extends when 0
- core_valid_o  out  1  one-cycle response pulse
- core_err_o  out  1  response is an error, qualified by core_valid_o
- core_rdata_o  out  32  aligned and extended load data
- bus_addr_o  out  32  {24'b0, addr[7:0]}
- bus_wdata_o  out  32  lane-replicated store data
- bus_we_o  out  1  write enable
- bus_be_o  out  4  byte enables
- bus_cs_o  out  N_SLAVES  one-hot chip select, doubles as strobe
- slv_rdata_i  in  32*N_SLAVES  slave read data; slave i occupies bits [32i+31:32i]
- slv_ack_i  in  N_SLAVES  slave acknowledge

## Operation
- FSM states: IDLE, ACCESS, RESP. core_ready_o = (state==IDLE).
- IDLE with core_req_i: register the address, data, we, hb and uns fields.
  - Legal access: go to ACCESS.
  - Error: go directly to RESP with err=1, and assert no cs. Error causes:
    - misaligned: half with addr[0]=1, or word with addr[1:0]≠0
    - hb=11
    - addr[31:16]≠0
    - addr[15:8] ≥ N_SLAVES
- ACCESS: drive the registered bus outputs and hold bus_cs_o[region] until slv_ack_i[region]=1. Acks from unselected slaves are ignored.
- On ack:
  - load: latch the extracted slv_rdata_i slice into core_rdata_o
  - store: core_rdata_o unchanged
  - then go to RESP
- RESP: core_valid_o=1 for exactly one cycle, bus_cs_o=0, then go to IDLE.
- Store lanes, with off=addr[1:0]:
  - byte: wdata={4{wdata[7:0]}}, be=4'b0001<<off
  - half: wdata={2{wdata[15:0]}}, be=4'b0011<<off
  - word: wdata as-is, be=4'b1111
- Load lanes:
  - byte: rdata[8*off+:8] extended to 32 bits
  - half: rdata[16*addr[1]+:16] extended to 32 bits
  - word: passed through
- Error response forces core_rdata_o=0.

## Timing
- Reset values: core_valid_o=0, core_err_o=0, core_rdata_o=0, all bus_* outputs=0, state=IDLE. core_ready_o is therefore 1 in the first cycle after reset.
- Request accepted at edge E0 → bus_cs_o valid after E0. A slave ack in cycle k of ACCESS moves the FSM to RESP at the next edge; core_valid_o is visible in the following cycle.
- Minimum latency is 3 cycles request-to-request (zero-wait slave: ack in the first ACCESS cycle). Error responses take 2 cycles.
- core_req_i is ignored while core_ready_o=0; the core holds its request until accepted.
- Reset asserted mid-access: at the next edge cs drops and the FSM returns to IDLE. No valid pulse is issued for the aborted access.
- An ack arriving in the same cycle as the timeout counter reaches its limit takes priority: the access completes normally.

## Configuration
- LSU_TIMEOUT_EN defined:
  - An 8-bit counter is cleared on entry to ACCESS and increments each ACCESS cycle.
  - When it reaches TIMEOUT_CYCLES with no ack, cs drops and the FSM goes to RESP with err=1.
  - TIMEOUT_CYCLES must be ≤ 255.
- LSU_TIMEOUT_EN undefined: the counter is absent and ACCESS waits indefinitely for an ack.

## Structure
- Package lsu_pkg holds:
  - HB_BYTE/HB_HALF/HB_WORD encodings
  - FSM state enum
  - REGION_SHIFT=8 and ROM_IDX/RAM_IDX/UART_IDX constants
- Sub-module lsu_lane (combinational): store replication and byte-enable generation, plus load extraction and extension. Instantiated once.

## Test plan
- Word store to 0x104 with RAM acking after 2 waits → bus_cs_o=3'b010, bus_be_o=4'b1111, bus_addr_o=0x04; core_valid_o pulses with err=0.
- Byte load from 0x003, uns=0, ROM data 0x80AABBCC → core_rdata_o=0xFFFFFF80. Repeat with uns=1 → 0x00000080.
- Half store of 0x1234 to 0x202 → bus_wdata_o=0x12341234, bus_be_o=4'b1100, bus_cs_o=3'b100.
- Word access to 0x102, and any access to 0x300 with N_SLAVES=3 → no cs asserted, valid+err after 2 cycles, rdata=0.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=16, load to UART with no ack → cs high for 16 cycles, then valid+err. Without the macro, cs stays high after 100 cycles.
- rst_i asserted in ACCESS cycle 1 → cs=0 and ready=1 at the next edge, no valid pulse. A subsequent request completes normally.
